// File: rtl/alu_seq_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode values (0..6 unchanged from the old combinational ALU)
//   - FSM state encoding
//   - is_iter(): selects the opcodes that use the multi-cycle mul/div unit
package alu_pkg;

  localparam logic [31:0] OP_ADD   = 32'd0;
  localparam logic [31:0] OP_SUB   = 32'd1;
  localparam logic [31:0] OP_AND   = 32'd2;
  localparam logic [31:0] OP_OR    = 32'd3;
  localparam logic [31:0] OP_XOR   = 32'd4;
  localparam logic [31:0] OP_SLL   = 32'd5;
  localparam logic [31:0] OP_SRL   = 32'd6;
  localparam logic [31:0] OP_SRA   = 32'd7;
  localparam logic [31:0] OP_SLT   = 32'd8;
  localparam logic [31:0] OP_SLTU  = 32'd9;
  localparam logic [31:0] OP_MUL   = 32'd10;
  localparam logic [31:0] OP_MULHU = 32'd11;
  localparam logic [31:0] OP_DIVU  = 32'd12;
  localparam logic [31:0] OP_REMU  = 32'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iter(input logic [31:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle of the sequential ALU.
//   slave  : the ALU side (takes operands, drives result and flags)
//   master : the producer/consumer side
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OPW-1:0]   opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             SF;
  logic             ZF;
  logic             CF;
  logic             OF;
  logic             err;

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, SF, ZF, CF, OF, err
  );

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, SF, ZF, CF, OF, err
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle multiply / divide unit.
//   start : load operands and begin (counter = WIDTH)
//   op    : 0 MUL, 1 MULHU, 2 DIVU, 3 REMU
//   A, B  : operands, sampled on start
//   done  : all WIDTH steps finished, res is valid this cycle
//   res   : selected half of the accumulator
// The 2*WIDTH accumulator holds {partial product, multiplier} for multiply
// and {remainder, quotient} for restoring division.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               run_q, run_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_win;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;

  always_comb begin
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    run_d = run_q;

    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    // Partial remainder after the left shift can need WIDTH+1 bits.
    rem_win  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = rem_win >= {1'b0, b_q};
    // When rem_ge holds the difference is < b_q, so WIDTH bits suffice.
    rem_diff = rem_win[WIDTH-1:0] - b_q;

    if (start) begin
      b_d   = B;
      acc_d = {{WIDTH{1'b0}}, A};
      cnt_d = CW'(WIDTH);
      op_d  = op;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
        if (!op_q[1]) begin
          acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:1]};
        end else begin
          // Divisor 0 always "fits": quotient all ones, remainder ends as A.
          acc_d = rem_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[2*WIDTH-2:0], 1'b0};
        end
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      run_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && (cnt_q == '0);
  // MUL/DIVU take the low half, MULHU/REMU the high half.
  assign res  = op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_if.slave (in_valid/in_ready/A/B/opcode in,
//                out_valid/out_ready/result/SF/ZF/CF/OF/err out)
// Single-cycle ops are computed combinationally and registered on accept;
// MUL/MULHU/DIVU/REMU run in alu_muldiv_iter while the FSM sits in BUSY.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 7
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sf_q, sf_d, zf_q, zf_d, cf_q, cf_d, of_q, of_d, err_q, err_d;

  logic [31:0]      op32;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cf, sc_of, sc_err;
  logic             in_ready, accept;
  logic             md_start, md_done;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] md_res;

  assign op32   = 32'(bus.opcode);
  assign shamt  = bus.B[SHW-1:0];
  // 10,11,12,13 -> 0,1,2,3
  assign md_op  = op32[1:0] ^ 2'b10;

  always_comb begin
    sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
    diff_w = {1'b0, bus.A} - {1'b0, bus.B};
    sc_res = '0;
    sc_cf  = 1'b0;
    sc_of  = 1'b0;
    sc_err = 1'b0;
    case (op32)
      OP_ADD: begin
        sc_res = sum_w[WIDTH-1:0];
        sc_cf  = sum_w[WIDTH];
        sc_of  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff_w[WIDTH-1:0];
        sc_cf  = diff_w[WIDTH];
        sc_of  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  sc_res = bus.A & bus.B;
      OP_OR:   sc_res = bus.A | bus.B;
      OP_XOR:  sc_res = bus.A ^ bus.B;
      OP_SLL:  sc_res = bus.A << shamt;
      OP_SRL:  sc_res = bus.A >> shamt;
      OP_SRA:  sc_res = $signed(bus.A) >>> shamt;
      OP_SLT:  sc_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_SLTU: sc_res = WIDTH'(bus.A < bus.B);
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: ;
      default: sc_err = 1'b1;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    sf_d     = sf_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    of_d     = of_q;
    err_d    = err_q;
    md_start = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_iter(op32)) begin
            state_d  = ST_BUSY;
            md_start = 1'b1;
          end else begin
            state_d  = ST_DONE;
            result_d = sc_res;
            sf_d     = sc_res[WIDTH-1];
            zf_d     = (sc_res == '0);
            cf_d     = sc_cf;
            of_d     = sc_of;
            err_d    = sc_err;
          end
        end else if ((state_q == ST_DONE) && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d  = ST_DONE;
          result_d = md_res;
          sf_d     = md_res[WIDTH-1];
          zf_d     = (md_res == '0);
          cf_d     = 1'b0;
          of_d     = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      sf_q     <= 1'b0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      sf_q     <= sf_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
      err_q    <= err_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (md_op),
    .A     (bus.A),
    .B     (bus.B),
    .done  (md_done),
    .res   (md_res)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.SF        = sf_q;
  assign bus.ZF        = zf_q;
  assign bus.CF        = cf_q;
  assign bus.OF        = of_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + short random bench for alu_seq (WIDTH=32). Expected results come
// from an arithmetic reference model and travel through a scoreboard queue.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        sf, zf, cf, of, err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32), .OPW(7)) bus ();

  alu_seq #(.WIDTH(32), .OPW(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   lat_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] w;
    logic [63:0] p;
    e = '0;
    p = 64'(a) * 64'(b);
    case (op)
      0: begin w = 33'(a) + 33'(b); e.res = w[31:0]; e.cf = w[32];
               e.of = (a[31] == b[31]) && (e.res[31] != a[31]); end
      1: begin e.res = a - b; e.cf = (a < b);
               e.of = (a[31] != b[31]) && (e.res[31] != a[31]); end
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = a ^ b;
      5: e.res = a << b[4:0];
      6: e.res = a >> b[4:0];
      7: e.res = $signed(a) >>> b[4:0];
      8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: e.res = (a < b) ? 32'd1 : 32'd0;
      10: e.res = p[31:0];
      11: e.res = p[63:32];
      12: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: e.res = (b == 0) ? a : a % b;
      default: begin e.res = 32'd0; e.err = 1'b1; end
    endcase
    e.sf = e.res[31];
    e.zf = (e.res == 32'd0);
    return e;
  endfunction

  task automatic drive_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
    bit acc = 0;
    sb.push_back(model(op, a, b));
    lat_q.push_back((op >= 10 && op <= 13) ? 33 : 0);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.opcode   = 7'(op);
    for (int n = 0; n < 100; n++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk); #1;
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    assert (acc === 1'b1) else begin
      failures++;
      $error("FAIL %s accept: observed=%0d expected=1", tag, acc);
    end
    if (!acc) begin
      void'(sb.pop_back());
      void'(lat_q.pop_back());
    end
  endtask

  task automatic check_out(input string tag, input bit consume);
    int   lat = 0;
    bit   got = 0;
    exp_t e;
    exp_t o;
    int   el;
    for (int n = 0; n < 100; n++) begin
      if (bus.out_valid === 1'b1) begin
        got = 1;
        break;
      end
      checks++;
      assert (bus.in_ready === 1'b0) else begin
        failures++;
        $error("FAIL %s busy_in_ready: observed=%b expected=0", tag, bus.in_ready);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    assert (got === 1'b1) else begin
      failures++;
      $error("FAIL %s out_valid_timeout: observed=%0d expected=1", tag, got);
    end
    if (got && sb.size() > 0) begin
      e  = sb.pop_front();
      el = lat_q.pop_front();
      o  = {bus.result, bus.SF, bus.ZF, bus.CF, bus.OF, bus.err};
      checks++;
      assert (o === e) else begin
        failures++;
        $error("FAIL %s result/SZCOE: observed=%h/%b%b%b%b%b expected=%h/%b%b%b%b%b",
               tag, o.res, o.sf, o.zf, o.cf, o.of, o.err, e.res, e.sf, e.zf, e.cf, e.of, e.err);
      end
      checks++;
      assert (lat === el) else begin
        failures++;
        $error("FAIL %s latency: observed=%0d expected=%0d", tag, lat, el);
      end
      if (consume) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [38:0] outs;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    outs = {bus.out_valid, bus.result, bus.SF, bus.ZF, bus.CF, bus.OF, bus.err};
    checks++;
    assert (outs === 39'd0) else begin
      failures++;
      $error("FAIL reset_outputs: observed=%h expected=0", outs);
    end
    checks++;
    assert (bus.in_ready === 1'b1) else begin
      failures++;
      $error("FAIL reset_in_ready: observed=%b expected=1", bus.in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops
    drive_op("add_wrap", 0, 32'hFFFF_FFFF, 32'h1);         check_out("add_wrap", 1);
    drive_op("sub_ovf", 1, 32'h8000_0000, 32'h1);          check_out("sub_ovf", 1);
    drive_op("slt", 8, 32'hFFFF_FFFF, 32'h0);              check_out("slt", 1);
    drive_op("sltu", 9, 32'hFFFF_FFFF, 32'h0);             check_out("sltu", 1);
    drive_op("sra", 7, 32'h8000_0000, 32'h0000_0104);      check_out("sra", 1);
    drive_op("sll", 5, 32'h8000_0000, 32'h0000_0104);      check_out("sll", 1);
    drive_op("srl", 6, 32'hF000_000F, 32'h0000_0021);      check_out("srl", 1);
    drive_op("and", 2, 32'hF0F0_1234, 32'h0FF0_FF00);      check_out("and", 1);

    // Back-to-back: accept the next op in the DONE cycle
    drive_op("b2b_or", 3, 32'h0000_00F0, 32'h0000_000F);   check_out("b2b_or", 0);
    drive_op("b2b_xor", 4, 32'hAAAA_5555, 32'hFFFF_0000);  check_out("b2b_xor", 1);

    // Iterative ops
    drive_op("mul", 10, 32'h0001_0003, 32'h0002_0005);     check_out("mul", 1);
    drive_op("mulhu", 11, 32'h0001_0003, 32'h0002_0005);   check_out("mulhu", 1);
    drive_op("divu", 12, 32'd100, 32'd7);                  check_out("divu", 1);
    drive_op("remu", 13, 32'd100, 32'd7);                  check_out("remu", 1);
    drive_op("mulhu_max", 11, 32'hFFFF_FFFF, 32'hFFFF_FFFF); check_out("mulhu_max", 1);

    // Divide by zero with back-pressure
    bus.out_ready = 1'b0;
    drive_op("divu_zero", 12, 32'h1234_5678, 32'h0);       check_out("divu_zero", 0);
    held = bus.result;
    bus.in_valid = 1'b1;
    bus.A        = 32'd1;
    bus.B        = 32'd1;
    bus.opcode   = 7'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      assert ({bus.out_valid, bus.in_ready, bus.result} === {1'b1, 1'b0, held}) else begin
        failures++;
        $error("FAIL hold_stable: observed=%b/%b/%h expected=1/0/%h",
               bus.out_valid, bus.in_ready, bus.result, held);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    assert (bus.out_valid === 1'b0) else begin
      failures++;
      $error("FAIL hold_no_second_op: observed=%b expected=0", bus.out_valid);
    end
    drive_op("remu_zero", 13, 32'd5, 32'd0);               check_out("remu_zero", 1);

    // Reset in the middle of a divide
    drive_op("divu_abort", 12, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    void'(lat_q.pop_back());
    outs = {bus.out_valid, bus.result, bus.SF, bus.ZF, bus.CF, bus.OF, bus.err};
    checks++;
    assert (outs === 39'd0) else begin
      failures++;
      $error("FAIL abort_outputs: observed=%h expected=0", outs);
    end
    checks++;
    assert (bus.in_ready === 1'b1) else begin
      failures++;
      $error("FAIL abort_in_ready: observed=%b expected=1", bus.in_ready);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_op("add_after_rst", 0, 32'd2, 32'd3);            check_out("add_after_rst", 1);
    checks++;
    assert (bus.out_valid === 1'b0) else begin
      failures++;
      $error("FAIL no_ghost_result: observed=%b expected=0", bus.out_valid);
    end

    // Undefined opcode
    drive_op("bad_op", 127, 32'hDEAD_BEEF, 32'h1);         check_out("bad_op", 1);
    drive_op("bad_op14", 14, 32'h1, 32'h1);                check_out("bad_op14", 1);

    // Short random mix
    for (int i = 0; i < 10; i++) begin
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      op = int'($urandom_range(0, 13));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      drive_op("rand", op, a, b);
      check_out("rand", 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle combinational ALU. It registers its result and flags, and adds arithmetic shift, signed/unsigned compare, and iterative multiply/divide/remainder. It sits between the decode/operand-fetch stage and writeback, where the core can stall on multi-cycle operations through valid/ready. Operation codes 0–6 keep their existing meaning, so existing decode logic remains valid.

## Interface
- `WIDTH`, default 32: operand/result width; must be ≥ 4 and a power of two.
- `OPW`, default 7: opcode width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and opcode are valid.
- `in_ready` output 1: the block accepts an operation this cycle.
- `A` input WIDTH: operand A.
- `B` input WIDTH: operand B.
- `opcode` input OPW: operation select.
- `out_valid` output 1: `result` and flags are valid.
- `out_ready` input 1: the consumer takes the result.
- `result` output WIDTH: registered result.
- `SF` output 1: `result[WIDTH-1]`.
- `ZF` output 1: asserted when `result == 0`.
- `CF` output 1: carry out for ADD; borrow (A <u B) for SUB; 0 otherwise.
- `OF` output 1: signed overflow for ADD/SUB; 0 otherwise.
- `err` output 1: undefined opcode (result 0).

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU: single-cycle.
  - 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU: iterative.
  - All other codes: `err`=1, result 0, single-cycle.
- Shift amount is `B[$clog2(WIDTH)-1:0]`; upper bits of B are ignored.
- SLT and SLTU return 1 or 0, zero-extended.
- Divide by zero: DIVU returns all-ones; REMU returns A. No `err` is raised.
- State machine: IDLE, BUSY, DONE.
  - IDLE: on accept of a single-cycle op, go to DONE; on accept of an iterative op, go to BUSY and load the iteration counter with WIDTH.
  - BUSY: run one shift-add (multiply) or restoring-subtract (divide) step per cycle. When the counter reaches 0, latch the result and go to DONE.
  - DONE: `out_valid`=1.
    - If `out_ready`=1 and a new op is accepted the same cycle, go to DONE or BUSY per the new op.
    - If `out_ready`=1 and no new op is accepted, go to IDLE.
    - If `out_ready`=0, hold.
- `in_ready` = (state==IDLE) or (state==DONE and `out_ready`). It is 0 throughout BUSY.
- While `out_valid`=1 and `out_ready`=0, `result` and all flags stay stable.
- `in_valid` with `in_ready`=0 is ignored. The source holds its inputs until accepted.

## Timing
- Reset (asynchronous):
  - state enters IDLE.
  - `out_valid`, `result`, `SF`, `ZF`, `CF`, `OF`, `err` clear to 0.
  - `in_ready` reads 1.
  - The iteration counter and partial registers clear.
- Reset asserted mid-BUSY aborts the operation; its result is never presented.
- Single-cycle op accepted at edge k: `out_valid` is 1 after edge k. Throughput is one op per cycle when `out_ready` is held at 1.
- Iterative op accepted at edge k: `out_valid` is 1 after edge k+WIDTH+1. The next op can be accepted in that same DONE cycle.
- Flags are computed from the final registered result (SF, ZF) or the ADD/SUB adder (CF, OF). They change only on the edge that loads `result`.

## Structure
- Package `alu_pkg`:
  - opcode localparams: `OP_ADD` … `OP_REMU`
  - state enum: `ST_IDLE`, `ST_BUSY`, `ST_DONE`
  - helper function `is_iter(opcode)`
- Sub-module `alu_muldiv_iter`: holds the iterative datapath.
  - Datapath registers: multiplicand/divisor, a 2*WIDTH accumulator/remainder, and the counter.
  - Ports: `start`, `op[1:0]`, `A`, `B`, `done`, `res`.
- The top level holds the combinational single-cycle datapath, the FSM and the output registers.

## Test plan
- ADD A=0xFFFFFFFF, B=1, `out_ready`=1 → result 0 one cycle after accept; ZF=1, CF=1, OF=0.
- SUB A=0x80000000, B=1 → result 0x7FFFFFFF; OF=1, CF=0, SF=0. SLT A=0xFFFFFFFF, B=0 → 1. SLTU with the same operands → 0.
- SRA A=0x80000000, B=0x00000104 → 0xF8000000; shift uses B[4:0]=4 only. SLL with the same operands → 0.
- MUL 0x0001_0003 × 0x0002_0005 → low word 0x000B_000F after exactly 33 edges. MULHU with the same operands → 0x0000_0002. `in_ready`=0 during BUSY.
- DIVU 100/7 → 14 and REMU 100/7 → 2. DIVU x/0 → 0xFFFFFFFF and REMU 5/0 → 5. Hold `out_ready`=0 for 5 cycles: result stays stable and no second op is accepted.
- Assert `rst_n`=0 at cycle 10 of a DIVU: all outputs are 0 immediately. After release, an ADD 2+3 returns 5 with no trace of the aborted op. Opcode 0x7F → `err`=1, result 0.
